// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller: RV32I width codes,
// FSM states and the small request-decode helpers used at request acceptance.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return !(funct3 == SB || funct3 == SH || funct3 == SW);
        return !(funct3 == LB || funct3 == LH || funct3 == LW ||
                 funct3 == LBU || funct3 == LHU);
    endfunction

    // The low two funct3 bits encode the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction: shifts the read word down to the
// addressed byte lane, then sign- or zero-extends according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            LB:      data = {{24{shifted[7]}}, shifted[7:0]};
            LH:      data = {{16{shifted[15]}}, shifted[15:0]};
            LW:      data = shifted;
            LBU:     data = {24'b0, shifted[7:0]};
            LHU:     data = {16'b0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core request at a time, issues a
// single memory beat, and returns an aligned result with error/misalign flags.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic        rsp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_e    state, state_next;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   rdata_q;
    logic          misalign_q;
    logic          err_q;

    logic          accept, capture, abort, expire;
    logic          req_mis, req_bad;
    logic [31:0]   load_data;

    assign req_mis = is_misaligned(req_funct3, req_addr[1:0]);
    assign req_bad = is_illegal(req_we, req_funct3) || req_mis;
    assign expire  = (cnt == CW'(TIMEOUT - 1));

    // Memory handshakes are checked ahead of expiry so a late grant still completes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = req_bad ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_next = we_q ? RESP : WAIT;
                end else if (expire) begin
                    abort      = 1'b1;
                    state_next = RESP;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else if (expire) begin
                    abort      = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                cnt        <= '0;
                we_q       <= req_we;
                funct3_q   <= req_funct3;
                addr_q     <= req_addr;
                wdata_q    <= store_data(req_funct3, req_wdata);
                be_q       <= req_we ? store_be(req_funct3, req_addr[1:0]) : 4'b1111;
                rdata_q    <= '0;
                misalign_q <= req_mis;
                err_q      <= is_illegal(req_we, req_funct3);
            end else if (state == REQ || state == WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (capture)
                rdata_q <= load_data;
            if (abort) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    // Outputs are qualified by state so an async reset clears them at once.
    assign req_ready    = (state == IDLE);
    assign mem_valid    = (state == REQ);
    assign mem_we       = mem_valid & we_q;
    assign mem_addr     = {addr_q[31:2], 2'b00};
    assign mem_be       = mem_valid ? be_q : 4'b0000;
    assign mem_wdata    = wdata_q;
    assign rsp_valid    = (state == RESP);
    assign rsp_rdata    = rsp_valid ? rdata_q : 32'h0;
    assign rsp_misalign = rsp_valid & misalign_q;
    assign rsp_err      = rsp_valid & err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a reference model predicts memory beats and
// responses at request acceptance; a monitor plays memory and checks both.
module tb_lsu_ctrl;

    localparam int TIMEOUT = 255;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        int          cyc;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        rsp_err;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rdy_delay = 0;
    int   rv_delay = 0;
    mem_t mem_q[$];
    rsp_t rsp_q[$];

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_misalign (rsp_misalign),
        .rsp_err      (rsp_err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model written lane by lane, independent of the RTL shift/case form.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rword,
                                  input int rdy_d, input int rv_d,
                                  output mem_t m, output rsp_t r, output bit access);
        int   n, off;
        logic ill, mis, tmo;
        off = int'(addr[1:0]);
        n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ill = we ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis = (off % n) != 0;
        tmo = !ill && !mis && (rdy_d > TIMEOUT - 1);
        access  = !ill && !mis && !tmo;
        m.we    = we;
        m.addr  = addr & 32'hFFFF_FFFC;
        m.be    = '0;
        m.wdata = '0;
        for (int i = 0; i < 4; i++) begin
            m.be[i] = !we || (i >= off && i < off + n);
            m.wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
        end
        r.rdata = '0;
        if (!we && access) begin
            for (int k = 0; k < 4; k++) begin
                if (k < n)
                    r.rdata[8*k +: 8] = rword[8*(off + k) +: 8];
                else
                    r.rdata[8*k +: 8] = (!f3[2] && rword[8*(off + n) - 1]) ? 8'hFF : 8'h00;
            end
        end
        r.err = ill || tmo;
        r.mis = mis;
        if (ill || mis)
            r.cyc = 1;
        else if (tmo)
            r.cyc = TIMEOUT + 1;
        else if (we)
            r.cyc = 2 + rdy_d;
        else
            r.cyc = 3 + rdy_d + rv_d;
    endfunction

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rword,
                                 input int rdy_d, input int rv_d, input bit push_rsp,
                                 output int acc);
        mem_t m;
        rsp_t r;
        bit   access;
        int   w;
        model(we, f3, addr, wdata, rword, rdy_d, rv_d, m, r, access);
        rdy_delay = rdy_d;
        rv_delay  = rv_d;
        mem_rdata = rword;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        w = 0;
        while (!req_ready && w < 600) begin
            @(negedge clk);
            w++;
        end
        acc = cyc;
        if (!req_ready) begin
            checkOutput("accept_wait", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        r.cyc = acc + r.cyc;
        if (push_rsp)
            rsp_q.push_back(r);
        if (access)
            mem_q.push_back(m);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 600 && rsp_q.size() != 0; i++)
            @(negedge clk);
        checkOutput("drain_rsp", rsp_q.size(), 0);
        checkOutput("drain_mem", mem_q.size(), 0);
        rsp_q.delete();
        mem_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // Memory model and response checker share one process to fix their ordering.
    initial begin : monitor
        int   v_cnt, r_cnt;
        bit   rd_pend;
        mem_t me;
        rsp_t re;
        v_cnt   = 0;
        r_cnt   = 0;
        rd_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                checkOutput("rsp_mem_valid", {31'b0, mem_valid}, 32'd0);
                checkOutput("rsp_req_ready", {31'b0, req_ready}, 32'd0);
                if (rsp_q.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    re = rsp_q.pop_front();
                    checkOutput("rsp_rdata", rsp_rdata, re.rdata);
                    checkOutput("rsp_misalign", {31'b0, rsp_misalign}, {31'b0, re.mis});
                    checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, re.err});
                    checkOutput("rsp_latency", cyc, re.cyc);
                end
            end
            mem_rvalid = 1'b0;
            if (rd_pend) begin
                if (r_cnt == rv_delay) begin
                    mem_rvalid = 1'b1;
                    rd_pend    = 1'b0;
                end
                r_cnt++;
            end
            if (mem_valid) begin
                if (v_cnt == rdy_delay) begin
                    mem_ready = 1'b1;
                    if (mem_q.size() == 0) begin
                        checkOutput("mem_unexpected", 32'd1, 32'd0);
                    end else begin
                        me = mem_q.pop_front();
                        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, me.we});
                        checkOutput("mem_addr", mem_addr, me.addr);
                        checkOutput("mem_be", {28'b0, mem_be}, {28'b0, me.be});
                        if (me.we)
                            checkOutput("mem_wdata", mem_wdata, me.wdata);
                    end
                    if (!mem_we) begin
                        rd_pend = 1'b1;
                        r_cnt   = 0;
                    end
                end else begin
                    mem_ready = 1'b0;
                end
                v_cnt++;
            end else begin
                mem_ready = 1'b0;
                v_cnt     = 0;
            end
        end
    end

    initial begin : stimulus
        int          acc, acc2, n;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  ld_f3[5];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_mem_be", {28'b0, mem_be}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_rsp_flags", {30'b0, rsp_misalign, rsp_err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed stores, loads, misaligned and illegal encodings.
        applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0, 1'b1, acc); waitIdle();
        applyStimulus(1'b1, 3'b001, 32'h0000_1002, 32'h1234_CDEF, 32'h0, 1, 0, 1'b1, acc); waitIdle();
        applyStimulus(1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b1, acc); waitIdle();
        applyStimulus(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_8056, 0, 0, 1'b1, acc); waitIdle();
        applyStimulus(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_8056, 0, 0, 1'b1, acc); waitIdle();
        applyStimulus(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h9ABC_0000, 2, 3, 1'b1, acc); waitIdle();
        applyStimulus(1'b0, 3'b101, 32'h0000_2000, 32'h0, 32'h9ABC_8001, 0, 1, 1'b1, acc); waitIdle();
        applyStimulus(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h89AB_CDEF, 0, 0, 1'b1, acc); waitIdle();
        applyStimulus(1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h7F00_0000, 0, 0, 1'b1, acc); waitIdle();
        applyStimulus(1'b0, 3'b010, 32'h0000_2002, 32'h0, 32'h1111_2222, 0, 0, 1'b1, acc); waitIdle();
        applyStimulus(1'b1, 3'b001, 32'h0000_1001, 32'h0000_5555, 32'h0, 0, 0, 1'b1, acc); waitIdle();
        applyStimulus(1'b0, 3'b011, 32'h0000_2000, 32'h0, 32'h3333_4444, 0, 0, 1'b1, acc); waitIdle();
        applyStimulus(1'b1, 3'b100, 32'h0000_1000, 32'h0000_0077, 32'h0, 0, 0, 1'b1, acc); waitIdle();

        // Back-to-back stores: next acceptance no sooner than three cycles apart.
        applyStimulus(1'b1, 3'b000, 32'h0000_1010, 32'h0000_0011, 32'h0, 0, 0, 1'b1, acc);
        applyStimulus(1'b1, 3'b000, 32'h0000_1011, 32'h0000_0022, 32'h0, 0, 0, 1'b1, acc2);
        checkOutput("b2b_period", acc2 - acc, 32'd3);
        waitIdle();

        // Timeout abort, and a grant landing on the expiry cycle.
        applyStimulus(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 100000, 0, 1'b1, acc); waitIdle();
        applyStimulus(1'b1, 3'b010, 32'h0000_1008, 32'h0BAD_CAFE, 32'h0, TIMEOUT - 1, 0, 1'b1, acc); waitIdle();

        // Reset during REQ must drop the memory request immediately.
        applyStimulus(1'b0, 3'b010, 32'h0000_2010, 32'h0, 32'h0, 100000, 0, 1'b0, acc);
        repeat (2) @(negedge clk);
        checkOutput("pre_rst_mem_valid", {31'b0, mem_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_mem_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("arst_mem_be", {28'b0, mem_be}, 32'd0);
        checkOutput("arst_mem_addr", mem_addr, 32'd0);
        checkOutput("arst_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        waitIdle();

        // Reset during WAIT: the late read data must not produce a response.
        applyStimulus(1'b0, 3'b010, 32'h0000_2020, 32'h0, 32'h55AA_55AA, 0, 4, 1'b0, acc);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("wrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("wrst_mem_valid", {31'b0, mem_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        waitIdle();
        applyStimulus(1'b0, 3'b010, 32'h0000_2030, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b1, acc); waitIdle();

        // Random legal, aligned traffic with small memory delays.
        for (int t = 0; t < 16; t++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            addr = $urandom;
            n    = (f3[1:0] == 2'b00) ? 0 : (f3[1:0] == 2'b01) ? 1 : 3;
            addr = addr & ~32'(n);
            applyStimulus(we, f3, addr, $urandom, $urandom,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, acc);
            waitIdle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
